// File: rtl/rsa_pkg.sv
// ============================================================================
//  Module   : rsa_pkg
//  Desc     : Shared RSA types and constants (state enum, key-width helper).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rsa_pkg;

    // Prime width shared with the key-generation IP.
    localparam int c_rsa_width = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } rsa_state_t;

    // Key and data width: twice the prime width.
    function automatic int ew_of(input int width);
        return 2 * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_mod_mul.sv
// ============================================================================
//  Module   : rsa_mod_mul
//  Desc     : Combinational (a*b) mod n over EW-bit operands; n=0 yields 0.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rsa_mod_mul #(
    parameter int EW = 8
) (
    input  logic [EW-1:0] i_a,
    input  logic [EW-1:0] i_b,
    input  logic [EW-1:0] i_n,
    output logic [EW-1:0] o_r
);

    logic [2*EW-1:0] w_prod;

    always_comb begin
        w_prod = {{EW{1'b0}}, i_a} * {{EW{1'b0}}, i_b};
        o_r    = '0;
        if (i_n != '0) begin
            o_r = EW'(w_prod % {{EW{1'b0}}, i_n});
        end
    end

endmodule

`default_nettype wire

// File: rtl/rsa_modexp.sv
// ============================================================================
//  Module   : rsa_modexp
//  Desc     : Left-to-right square-and-multiply M = C^D mod N, one product per
//             cycle. RSA_MODEXP_SKIP_LEADING_EN starts at the top set bit of D.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int  WIDTH = c_rsa_width,
    localparam int EW    = ew_of(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [EW-1:0] in_n,
    input  logic [EW-1:0] in_d,
    input  logic [EW-1:0] in_c,
    output logic          busy,
    output logic          out_valid,
    output logic [EW-1:0] out_m
);

    localparam int IW = $clog2(EW);

    rsa_state_t    r_state;
    logic [EW-1:0] r_n;
    logic [EW-1:0] r_d;
    logic [EW-1:0] r_base;
    logic [EW-1:0] r_acc;
    logic [IW-1:0] r_idx;
    logic          r_busy;
    logic          r_valid;
    logic [EW-1:0] r_m;

    logic [EW-1:0] w_mul_a;
    logic [EW-1:0] w_mul_b;
    logic [EW-1:0] w_mul_n;
    logic [EW-1:0] w_mul_r;
    logic [EW-1:0] w_acc_init;
    logic [IW-1:0] w_load_idx;
    rsa_state_t    w_load_state;

`ifdef RSA_MODEXP_SKIP_LEADING_EN
    function automatic logic [IW-1:0] msb_idx(input logic [EW-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < EW; i++) begin
            if (v[i]) msb_idx = IW'(i);
        end
    endfunction

    assign w_load_idx   = msb_idx(in_d);
    assign w_load_state = (in_d == '0) ? DONE : SQR;
`else
    assign w_load_idx   = IW'(EW - 1);
    assign w_load_state = SQR;
`endif

    // 1 mod N collapses to 0 for N<=1, so N=0 and N=1 both finish at 0.
    assign w_acc_init = (in_n > EW'(1)) ? EW'(1) : '0;

    // The single multiplier also performs the C mod N reduction at load.
    always_comb begin
        w_mul_a = r_acc;
        w_mul_b = r_acc;
        w_mul_n = r_n;
        case (r_state)
            IDLE: begin
                w_mul_a = in_c;
                w_mul_b = EW'(1);
                w_mul_n = in_n;
            end
            MUL:     w_mul_b = r_base;
            default: ;
        endcase
    end

    rsa_mod_mul #(.EW(EW)) u_mod_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .i_n (w_mul_n),
        .o_r (w_mul_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_d     <= '0;
            r_base  <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_m     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    r_m     <= '0;
                    r_busy  <= in_valid;
                    if (in_valid) begin
                        r_n     <= in_n;
                        r_d     <= in_d;
                        r_base  <= w_mul_r;
                        r_acc   <= w_acc_init;
                        r_idx   <= w_load_idx;
                        r_state <= w_load_state;
                    end
                end
                SQR: begin
                    r_acc   <= w_mul_r;
                    r_state <= MUL;
                end
                MUL: begin
                    if (r_d[r_idx]) r_acc <= w_mul_r;
                    if (r_idx == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= SQR;
                    end
                end
                DONE: begin
                    r_valid <= 1'b1;
                    r_m     <= r_acc;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_m     = r_m;

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp.sv
// ============================================================================
//  Module   : tb_rsa_modexp
//  Desc     : Directed scoreboard bench for rsa_modexp.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rsa_modexp;
    import rsa_pkg::*;

    localparam int WIDTH = c_rsa_width;
    localparam int EW    = ew_of(WIDTH);

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [EW-1:0] in_n     = '0;
    logic [EW-1:0] in_d     = '0;
    logic [EW-1:0] in_c     = '0;
    logic          busy;
    logic          out_valid;
    logic [EW-1:0] out_m;

    int     vectors     = 0;
    int     miscompares = 0;
    int     pulses      = 0;
    longint exp_q[$];

    rsa_modexp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_n      (in_n),
        .in_d      (in_d),
        .in_c      (in_c),
        .busy      (busy),
        .out_valid (out_valid),
        .out_m     (out_m)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) pulses++;
    end

    // Reference by repeated multiplication, independent of bit scanning.
    function automatic longint ref_modexp(input longint n, input longint d, input longint c);
        longint r;
        longint b;
        if (n == 0) return 0;
        r = 1 % n;
        b = c % n;
        for (longint i = 0; i < d; i++) r = (r * b) % n;
        return r;
    endfunction

    function automatic int exp_lat(input int d);
`ifdef RSA_MODEXP_SKIP_LEADING_EN
        int m;
        m = -1;
        for (int i = 0; i < EW; i++) if (d[i]) m = i;
        return (m < 0) ? 1 : 2 * (m + 1) + 1;
`else
        if (d < 0) return 0;
        return 2 * EW + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request; optionally pulse a junk request after edges inj_a/inj_b.
    task automatic run_req(input string tag, input int n, input int d, input int c,
                           input int inj_a, input int inj_b);
        int     lat;
        int     cnt;
        logic   seen;
        longint exp;
        @(negedge clk);
        in_n     = EW'(n);
        in_d     = EW'(d);
        in_c     = EW'(c);
        in_valid = 1'b1;
        exp_q.push_back(ref_modexp(n, d, c));
        lat = exp_lat(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            if (cnt == inj_a || cnt == inj_b) begin
                in_valid = 1'b1;
                in_n     = EW'(13);
                in_d     = EW'(3);
                in_c     = EW'(2);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cnt++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        in_valid = 1'b0;
        exp = exp_q.pop_front();
        chk({tag, "_lat"}, 64'(cnt), 64'(lat));
        chk({tag, "_m"}, {{(64-EW){1'b0}}, out_m}, 64'(exp));
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_vld_lo"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_m_zero"}, {{(64-EW){1'b0}}, out_m}, 64'd0);
        chk({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_vld", {63'd0, out_valid}, 64'd0);
        chk("rst_m", {{(64-EW){1'b0}}, out_m}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("n55", 55, 27, 8, -1, -1);
        idle_check("n55");

        run_req("b2b_dec", 21, 5, 16, -1, -1);
        run_req("b2b_enc", 21, 5, 4, -1, -1);
        idle_check("b2b");

        run_req("n1", 1, 9, 7, -1, -1);
        idle_check("n1");
        run_req("d0", 55, 0, 30, -1, -1);
        idle_check("d0");
        run_req("n0", 0, 27, 9, -1, -1);
        idle_check("n0");
        run_req("cgen", 55, 1, 60, -1, -1);
        idle_check("cgen");

        p0 = pulses;
        run_req("ign", 55, 27, 8, 4, exp_lat(27) - 1);
        idle_check("ign");
        repeat (25) @(posedge clk);
        #1;
        chk("ign_pulses", 64'(pulses - p0), 64'd1);

        // Reset while the engine is in its first SQR cycle.
        @(negedge clk);
        in_n     = EW'(55);
        in_d     = EW'(27);
        in_c     = EW'(8);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        p0 = pulses;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_vld", {63'd0, out_valid}, 64'd0);
        chk("arst_m", {{(64-EW){1'b0}}, out_m}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("arst_no_pulse", 64'(pulses - p0), 64'd0);
        chk("arst_idle", {63'd0, busy}, 64'd0);
        run_req("post_rst", 55, 27, 8, -1, -1);
        idle_check("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
